// File: rtl/imem_boot_loader_pkg.sv
// Shared types and stream-format constants for the imem boot loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
package imem_boot_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_W      = LEN_BYTES * BYTE_W;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_WORD   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem write port of the boot loader.
interface imem_boot_loader_if;

    logic [imem_boot_loader_pkg::BYTE_W-1:0] InByte;
    logic                                    InValid;
    logic                                    InReady;
    logic                                    ImemWrite;
    logic [imem_boot_loader_pkg::ADDR_W-1:0] ImemAddr;
    logic [imem_boot_loader_pkg::WORD_W-1:0] ImemWData;

    // Host side: sources bytes, observes the imem write port.
    modport master (
        output InByte, InValid,
        input  InReady, ImemWrite, ImemAddr, ImemWData
    );

    // Loader side.
    modport slave (
        input  InByte, InValid,
        output InReady, ImemWrite, ImemAddr, ImemWData
    );

endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Shifts accepted bytes (MSB first) into a word and flags the fourth byte.
module imem_boot_loader_byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word_c,
    output logic              word_ready_c
);

    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic [CNT_W-1:0]         cnt_q;

    // Word as it will look once the incoming byte lands.
    assign word_c       = {shift_q, in_byte};
    assign word_ready_c = shift_en && (cnt_q == CNT_W'(WORD_BYTES - 1));

    // Byte shift register and 0..3 byte counter; counter wraps on the last byte.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= word_c[WORD_W-BYTE_W-1:0];
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed byte stream -> imem words; holds the CPU in reset until loaded.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned       MAX_WORDS = 1024
) (
    input  logic                 Clk,
    input  logic                 Reset,
    imem_boot_loader_if.slave    bus,
    output logic                 CpuReset,
    output logic                 LoadDone,
    output logic                 LoadError
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_POST = ST_CSUM;
`else
    localparam state_t ST_POST = ST_DONE;
`endif

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   len_hi_q, len_hi_d;
    logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]    word_idx_q, word_idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

    logic                in_ready_q, in_ready_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [LEN_W-1:0]    len_word;
    logic [WORD_W-1:0]   word_c;
    logic                word_ready_c;

    assign accept   = bus.InValid && in_ready_q;
    assign len_word = {len_hi_q, bus.InByte};

    imem_boot_loader_byte_word_packer u_packer (
        .Clk          (Clk),
        .Reset        (Reset),
        .shift_en     (accept && (state_q == ST_WORD)),
        .in_byte      (bus.InByte),
        .word_c       (word_c),
        .word_ready_c (word_ready_c)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = accept ? (csum_q ^ bus.InByte) : csum_q;
`endif
        wr_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = bus.InByte;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    word_cnt_d = len_word;
                    word_idx_d = '0;
                    if (32'(len_word) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (len_word == '0) begin
                        state_d = ST_POST;
                    end else begin
                        state_d = ST_WORD;
                    end
                end
            end
            ST_WORD: begin
                if (word_ready_c) begin
                    wr_d       = 1'b1;
                    wdata_d    = word_c;
                    addr_d     = BASE_ADDR + ADDR_W'(word_idx_q) * ADDR_W'(WORD_BYTES);
                    word_idx_d = word_idx_q + LEN_W'(1);
                    if (word_idx_q == word_cnt_q - LEN_W'(1)) begin
                        state_d = ST_POST;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (bus.InByte == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_LEN_HI;
        endcase

        in_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                     (state_d == ST_WORD)   || (state_d == ST_CSUM);
        done_d     = (state_q == ST_DONE);
        err_d      = (state_q == ST_ERR);
        cpu_rst_d  = !done_d;
    end

    // State, counters and registered outputs; Reset drops any pending write strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_LEN_HI;
            len_hi_q   <= '0;
            word_cnt_q <= '0;
            word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
            in_ready_q <= in_ready_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.InReady   = in_ready_q;
    assign bus.ImemWrite = wr_q;
    assign bus.ImemAddr  = addr_q;
    assign bus.ImemWData = wdata_q;
    assign CpuReset      = cpu_rst_q;
    assign LoadDone      = done_q;
    assign LoadError     = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: vector table of images plus hand-written corner sequences,
// imem writes checked against an expected-write queue.
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 1024;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic CpuReset, LoadDone, LoadError;

    imem_boot_loader_if bus ();

    imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .CpuReset  (CpuReset),
        .LoadDone  (LoadDone),
        .LoadError (LoadError)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          gap;
        bit          len_err;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   last_wr_cyc = 0;
    int   done_cyc = 0;
    bit   done_seen = 1'b0;
    wr_t  exp_q[$];
    logic [31:0] img [0:1023];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] tb_csum;
    bit         csum_corrupt = 1'b0;
`endif

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every write strobe pops one expected write.
    always @(negedge Clk) begin
        wr_t e;
        if (Reset) done_seen = 1'b0;
        else if (LoadDone && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (bus.ImemWrite === 1'b1) begin
            wr_count++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", bus.ImemAddr, bus.ImemWData);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.ImemAddr, e.addr);
                check("wr_data", bus.ImemWData, e.data);
            end
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        bus.InValid = 1'b0;
        bus.InByte  = 8'h00;
        repeat (2) @(negedge Clk);
        exp_q.delete();
        Reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        bus.InByte  = b;
        bus.InValid = 1'b1;
        while (bus.InReady !== 1'b1 && t < 50) begin
            @(negedge Clk);
            t++;
        end
        if (bus.InReady !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: byte %h, InReady %b after %0d cycles, expected 1", b, bus.InReady, t);
            bus.InValid = 1'b0;
            return;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        tb_csum = tb_csum ^ b;
`endif
        @(negedge Clk);
        bus.InValid = 1'b0;
        if (gap) begin
            bus.InByte = 8'hFF;
            @(negedge Clk);
        end
    endtask

    task automatic send_image(input logic [15:0] len, input int nw, input bit gap, input bit len_err);
        logic [31:0] w;
`ifdef IMEM_LOADER_CHECKSUM_EN
        tb_csum = 8'h00;
`endif
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
        if (len_err) return;
        for (int i = 0; i < nw; i++) begin
            w = img[i];
            for (int b = 0; b < 4; b++) begin
                if (b == 3) exp_q.push_back('{addr: BASE + 32'(i) * 32'd4, data: w});
                send_byte(w[31 - 8*b -: 8], gap);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_csum ^ {7'b0, csum_corrupt}, gap);
`endif
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(LoadDone === 1'b1 || LoadError === 1'b1) && t < 30) begin
            @(negedge Clk);
            t++;
        end
        if (!(LoadDone === 1'b1 || LoadError === 1'b1)) begin
            n_tests++;
            n_fail++;
            $display("FAIL end_timeout: LoadDone %b LoadError %b after %0d cycles, expected one set", LoadDone, LoadError, t);
        end
        @(negedge Clk);
    endtask

    task automatic check_end(input bit exp_err, input int exp_writes, input int wr_before);
        check("load_done",      32'(LoadDone),  exp_err ? 32'd0 : 32'd1);
        check("load_error",     32'(LoadError), exp_err ? 32'd1 : 32'd0);
        check("cpu_reset",      32'(CpuReset),  exp_err ? 32'd1 : 32'd0);
        check("in_ready_final", 32'(bus.InReady), 32'd0);
        check("write_count",    32'(wr_count - wr_before), 32'(exp_writes));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   wb;

        vecs[0] = '{16'h0002, 2, 32'h2008_0005, 32'h0109_4820, 1'b0, 1'b0};
        vecs[1] = '{16'h0002, 2, 32'h2008_0005, 32'h0109_4820, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 0, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[3] = '{16'h0401, 0, 32'h0,         32'h0,         1'b0, 1'b1};
        vecs[4] = '{16'h0001, 1, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0};

        // Reset values while Reset is held.
        bus.InValid = 1'b0;
        bus.InByte  = 8'h00;
        repeat (3) @(negedge Clk);
        check("rst_in_ready",   32'(bus.InReady),   32'd0);
        check("rst_imem_write", 32'(bus.ImemWrite), 32'd0);
        check("rst_imem_addr",  bus.ImemAddr,       BASE);
        check("rst_imem_wdata", bus.ImemWData,      32'd0);
        check("rst_cpu_reset",  32'(CpuReset),      32'd1);
        check("rst_load_done",  32'(LoadDone),      32'd0);
        check("rst_load_error", 32'(LoadError),     32'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            img[0] = vecs[v].w0;
            img[1] = vecs[v].w1;
            wb = wr_count;
            send_image(vecs[v].len, vecs[v].nw, vecs[v].gap, vecs[v].len_err);
            wait_end();
            check_end(vecs[v].len_err, vecs[v].len_err ? 0 : vecs[v].nw, wb);
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (v == 0) check("done_after_last_write", 32'(done_cyc - last_wr_cyc), 32'd1);
`endif
        end

        // Reset after 6 payload bytes; leftover bytes must not leak into the next image.
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        exp_q.push_back('{addr: BASE, data: 32'h1122_3344});
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        @(negedge Clk);
        check("midload_pending", 32'(exp_q.size()), 32'd0);
        check("midload_cpu_reset", 32'(CpuReset), 32'd1);
        do_reset();
        img[0] = 32'hCAFE_F00D;
        wb = wr_count;
        send_image(16'h0001, 1, 1'b0, 1'b0);
        wait_end();
        check_end(1'b0, 1, wb);

        // Exactly MAX_WORDS words is accepted; last address is BASE + 4*(MAX-1).
        do_reset();
        for (int i = 0; i < 1024; i++) img[i] = {16'hA5A5, 16'(i)};
        wb = wr_count;
        send_image(16'h0400, 1024, 1'b0, 1'b0);
        wait_end();
        check_end(1'b0, 1024, wb);
        check("max_last_addr", bus.ImemAddr, BASE + 32'h0000_0FFC);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good checksum -> DONE; corrupted checksum -> ERROR after the write lands.
        do_reset();
        img[0] = 32'hAABB_CCDD;
        csum_corrupt = 1'b0;
        wb = wr_count;
        send_image(16'h0001, 1, 1'b0, 1'b0);
        wait_end();
        check_end(1'b0, 1, wb);

        do_reset();
        csum_corrupt = 1'b1;
        wb = wr_count;
        send_image(16'h0001, 1, 1'b0, 1'b0);
        wait_end();
        check_end(1'b1, 1, wb);
        csum_corrupt = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
